// File: rtl/i2c_target_mem.sv
// I2C target with a multi-byte register pointer and auto-increment bursts onto a
// synchronous memory port. SCL/SDA are oversampled on clk; SDA is driven open-drain.
module i2c_target_mem #(
  parameter logic [6:0]  DEVICE_ID   = 7'h2A,
  parameter int unsigned PTR_WIDTH   = 8,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          AUTO_INC    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic [PTR_WIDTH-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wren,
  output logic                 mem_rden,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 err_range
);

  localparam int unsigned PTR_BYTES = (PTR_WIDTH + 7) / 8;
  localparam int unsigned ACC_W     = PTR_BYTES * 8;
  localparam int unsigned PCW       = (PTR_BYTES > 1) ? $clog2(PTR_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK,
    RD_LOAD, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [PCW-1:0]       pcnt_q, pcnt_d;
  logic [1:0]           ld_cnt_q, ld_cnt_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_d, busy_d, err_d, wren_d, rden_d;
  logic [PTR_WIDTH-1:0] addr_d;
  logic [7:0]           wdata_d;

  logic [7:0]           byte_in;
  logic [ACC_W-1:0]     acc_new;
  logic [PTR_WIDTH-1:0] ptr_new, ptr_inc;
  logic                 byte_done, last_ptr_byte;

  // Pin synchronisers idle high so reset never looks like a bus event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & ~sda_p & sda_s;

  assign byte_in       = {shift_q[6:0], sda_s};
  assign byte_done     = scl_rise && (bit_cnt_q == 4'd7);
  assign acc_new       = ACC_W'({acc_q, byte_in});
  assign ptr_new       = acc_new[PTR_WIDTH-1:0];
  assign last_ptr_byte = (32'(pcnt_q) == PTR_BYTES - 1);
  assign ptr_inc       = (32'(ptr_q) == MEM_DEPTH - 1) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      acc_q     <= '0;
      pcnt_q    <= '0;
      ld_cnt_q  <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      err_range <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      pcnt_q    <= pcnt_d;
      ld_cnt_q  <= ld_cnt_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      err_range <= err_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_wren  <= wren_d;
      mem_rden  <= rden_d;
    end
  end

  // Next-state and outputs; bus conditions override any pending bit or byte
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    pcnt_d    = pcnt_q;
    ld_cnt_d  = ld_cnt_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    err_d     = err_range;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    wren_d    = 1'b0;
    rden_d    = 1'b0;

    if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      err_d     = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: ;

        DEV_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (byte_done) begin
            bit_cnt_d = '0;
            if (byte_in[7:1] == DEVICE_ID) begin
              rw_d    = byte_in[0];
              busy_d  = 1'b1;
              state_d = DEV_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end

        // ACK states use sda_oe itself to tell the drive fall from the release fall
        DEV_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              ld_cnt_d = '0;
              state_d  = RD_LOAD;
            end else begin
              pcnt_d  = '0;
              state_d = PTR;
            end
          end
        end

        PTR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (byte_done) begin
            bit_cnt_d = '0;
            acc_d     = acc_new;
            state_d   = PTR_ACK;
            if (last_ptr_byte) begin
              if (32'(ptr_new) >= MEM_DEPTH) begin
                err_d   = 1'b1;
                state_d = IGNORE;
              end else begin
                ptr_d = ptr_new;
              end
            end
          end
        end

        PTR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (last_ptr_byte) begin
              state_d = WR_DATA;
            end else begin
              pcnt_d  = pcnt_q + 1'b1;
              state_d = PTR;
            end
          end
        end

        WR_DATA: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (byte_done) begin
            bit_cnt_d = '0;
            state_d   = WR_ACK;
          end
        end

        WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_d = 1'b1;
            wren_d   = 1'b1;
            addr_d   = ptr_q;
            wdata_d  = shift_q;
            if (AUTO_INC) ptr_d = ptr_inc;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end

        // Issue read, wait one clk for the memory, capture; drive bit 7 now if SCL is low
        RD_LOAD: begin
          case (ld_cnt_q)
            2'd0: begin
              rden_d   = 1'b1;
              addr_d   = ptr_q;
              ld_cnt_d = 2'd1;
            end
            2'd1: ld_cnt_d = 2'd2;
            default: begin
              shift_d = mem_rdata;
              state_d = RD_DATA;
              if (!scl_s) begin
                sda_oe_d  = ~mem_rdata[7];
                bit_cnt_d = 4'd1;
              end else begin
                bit_cnt_d = 4'd0;
              end
            end
          endcase
        end

        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d  = ~shift_q[3'(4'd7 - bit_cnt_q)];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        RD_ACK: if (scl_rise) begin
          if (!sda_s) begin
            if (AUTO_INC) ptr_d = ptr_inc;
            ld_cnt_d = '0;
            state_d  = RD_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IGNORE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: three targets share one bus (default, MEM_DEPTH=200,
// PTR_WIDTH=12); expected writes/reads are queued and checked as the DUTs respond.
module tb_i2c_target_mem;

  localparam int HP = 16;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk, reset_n, m_scl, m_sda, sda_bus;
  logic oe_a, oe_b, oe_c;
  logic [7:0]  addr_a, addr_b;
  logic [11:0] addr_c;
  logic [7:0]  wdata_a, wdata_b, wdata_c, rdata_a, rdata_b, rdata_c;
  logic wren_a, wren_b, wren_c, rden_a, rden_b, rden_c;
  logic busy_a, busy_b, busy_c, err_a, err_b, err_c;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [4096];

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  int n_checks = 0;
  int n_errors = 0;
  int oe_cnt   = 0;
  int strb_a   = 0;

  assign sda_bus = m_sda & ~oe_a & ~oe_b & ~oe_c;

  i2c_target_mem #(.DEVICE_ID(7'h2A), .PTR_WIDTH(8), .MEM_DEPTH(256), .SYNC_STAGES(2), .AUTO_INC(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(oe_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_a), .mem_rden(rden_a),
    .mem_rdata(rdata_a), .busy(busy_a), .err_range(err_a));

  i2c_target_mem #(.DEVICE_ID(7'h31), .PTR_WIDTH(8), .MEM_DEPTH(200), .SYNC_STAGES(2), .AUTO_INC(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(oe_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_b), .mem_rden(rden_b),
    .mem_rdata(rdata_b), .busy(busy_b), .err_range(err_b));

  i2c_target_mem #(.DEVICE_ID(7'h32), .PTR_WIDTH(12), .MEM_DEPTH(4096), .SYNC_STAGES(2), .AUTO_INC(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(oe_c),
    .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_wren(wren_c), .mem_rden(rden_c),
    .mem_rdata(rdata_c), .busy(busy_c), .err_range(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories behind each target
  always @(posedge clk) begin
    if (wren_a) mem_a[addr_a] <= wdata_a;
    if (rden_a) rdata_a <= mem_a[addr_a];
    if (wren_b) mem_b[addr_b] <= wdata_b;
    if (rden_b) rdata_b <= mem_b[addr_b];
    if (wren_c) mem_c[addr_c] <= wdata_c;
    if (rden_c) rdata_c <= mem_c[addr_c];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_write(input logic [1:0] d, input logic [15:0] a, input logic [7:0] v);
    wr_t obs, e;
    obs = '{dut: d, addr: a, data: v};
    if (exp_wr.size() == 0) begin
      check("wr_unexpected", 32'(obs), 32'hFFFF_FFFF);
    end else begin
      e = exp_wr.pop_front();
      check("wr", 32'(obs), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (wren_a) sb_write(2'd0, 16'(addr_a), wdata_a);
    if (wren_b) sb_write(2'd1, 16'(addr_b), wdata_b);
    if (wren_c) sb_write(2'd2, 16'(addr_c), wdata_c);
    if (oe_a | oe_b | oe_c) oe_cnt++;
    if (wren_a | rden_a) strb_a++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(HP);
    m_scl = 1'b1; wait_clk(HP);
    m_sda = 1'b0; wait_clk(HP);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(HP);
    m_scl = 1'b1; wait_clk(HP);
    m_sda = 1'b1; wait_clk(HP);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_clk(HP);
    m_scl = 1'b1; wait_clk(HP);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_clk(HP);
    m_scl = 1'b1; wait_clk(HP / 2);
    b = sda_bus;  wait_clk(HP / 2);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic read_check(input string tag, input logic nack);
    logic [7:0] got;
    read_byte(nack, got);
    if (exp_rd.size() == 0) check({tag, "_unexpected"}, 32'(got), 32'hFFFF_FFFF);
    else check(tag, 32'(got), 32'(exp_rd.pop_front()));
  endtask

  initial begin
    logic ack, b;
    int s0, o0;
    reset_n = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);

    check("rst_oe", 32'(oe_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_addr", 32'(addr_a), 0);
    check("rst_strobes", 32'({wren_a, rden_a, wdata_a}), 0);

    // Write burst 0x10 <= A5, 0x11 <= 3C
    i2c_start();
    write_byte(8'h54, ack); check("wb_dev_ack", 32'(ack), 1);
    check("wb_busy", 32'(busy_a), 1);
    write_byte(8'h10, ack); check("wb_ptr_ack", 32'(ack), 1);
    exp_wr.push_back('{dut: 2'd0, addr: 16'h0010, data: 8'hA5});
    write_byte(8'hA5, ack); check("wb_d0_ack", 32'(ack), 1);
    exp_wr.push_back('{dut: 2'd0, addr: 16'h0011, data: 8'h3C});
    write_byte(8'h3C, ack); check("wb_d1_ack", 32'(ack), 1);
    i2c_stop();
    check("wb_busy_end", 32'(busy_a), 0);

    // Combined read: pointer write, Sr, read two bytes
    i2c_start();
    write_byte(8'h54, ack); check("rd_dev_ack", 32'(ack), 1);
    write_byte(8'h10, ack); check("rd_ptr_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'h55, ack); check("rd_dev2_ack", 32'(ack), 1);
    exp_rd.push_back(8'hA5);
    read_check("rd_b0", 1'b0);
    exp_rd.push_back(8'h3C);
    read_check("rd_b1", 1'b1);
    check("rd_release", 32'(oe_a), 0);
    check("rd_busy_nack", 32'(busy_a), 0);
    i2c_stop();

    // Wrong address: nobody drives SDA, no strobes
    s0 = strb_a; o0 = oe_cnt;
    i2c_start();
    write_byte(8'h56, ack); check("wa_nack", 32'(ack), 0);
    write_byte(8'h10, ack); check("wa_ptr_nack", 32'(ack), 0);
    i2c_stop();
    check("wa_oe_never", 32'(oe_cnt - o0), 0);
    check("wa_no_strobe", 32'(strb_a - s0), 0);
    i2c_start();
    write_byte(8'h54, ack); check("wa_next_ack", 32'(ack), 1);
    i2c_stop();

    // Pointer wrap: 0xFF then 0x00
    i2c_start();
    write_byte(8'h54, ack);
    write_byte(8'hFF, ack); check("wrap_ptr_ack", 32'(ack), 1);
    exp_wr.push_back('{dut: 2'd0, addr: 16'h00FF, data: 8'h11});
    write_byte(8'h11, ack);
    exp_wr.push_back('{dut: 2'd0, addr: 16'h0000, data: 8'h22});
    write_byte(8'h22, ack); check("wrap_d1_ack", 32'(ack), 1);
    i2c_stop();

    // Out-of-range pointer on the MEM_DEPTH=200 target
    i2c_start();
    write_byte(8'h62, ack); check("rng_dev_ack", 32'(ack), 1);
    write_byte(8'hC8, ack); check("rng_ptr_nack", 32'(ack), 0);
    check("rng_err", 32'(err_b), 1);
    write_byte(8'h55, ack); check("rng_data_ignored", 32'(ack), 0);
    i2c_stop();
    check("rng_err_sticky", 32'(err_b), 1);
    i2c_start();
    check("rng_err_clr", 32'(err_b), 0);
    write_byte(8'h62, ack);
    write_byte(8'hC7, ack); check("rng_last_ok", 32'(ack), 1);
    exp_wr.push_back('{dut: 2'd1, addr: 16'h00C7, data: 8'h77});
    write_byte(8'h77, ack);
    i2c_stop();

    // Abort: STOP after four data bits
    s0 = strb_a;
    i2c_start();
    write_byte(8'h54, ack);
    write_byte(8'h20, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    check("abort_no_wren", 32'(strb_a - s0), 0);
    check("abort_busy", 32'(busy_a), 0);

    // Reset while driving a read bit
    i2c_start();
    write_byte(8'h54, ack);
    write_byte(8'h10, ack);
    i2c_start();
    write_byte(8'h55, ack);
    recv_bit(b); check("rst_rd_b7", 32'(b), 1);
    recv_bit(b); check("rst_rd_b6", 32'(b), 0);
    recv_bit(b); check("rst_rd_b5", 32'(b), 1);
    m_sda = 1'b1; wait_clk(HP);
    m_scl = 1'b1; wait_clk(HP / 2);
    check("rst_oe_before", 32'(oe_a), 1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_oe_async", 32'(oe_a), 0);
    check("rst_busy_async", 32'(busy_a), 0);
    check("rst_addr_async", 32'(addr_a), 0);
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    i2c_start();
    write_byte(8'h54, ack); check("rst_recover_ack", 32'(ack), 1);
    i2c_stop();

    // 12-bit pointer: three ACKs before data, write at 0x123
    i2c_start();
    write_byte(8'h64, ack); check("wide_dev_ack", 32'(ack), 1);
    write_byte(8'h01, ack); check("wide_p0_ack", 32'(ack), 1);
    write_byte(8'h23, ack); check("wide_p1_ack", 32'(ack), 1);
    exp_wr.push_back('{dut: 2'd2, addr: 16'h0123, data: 8'h5A});
    write_byte(8'h5A, ack); check("wide_d_ack", 32'(ack), 1);
    i2c_stop();

    wait_clk(8);
    check("wr_queue_empty", 32'(exp_wr.size()), 0);
    check("rd_queue_empty", 32'(exp_rd.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
